// File: rtl/median_window_feeder_if.sv
// Pixel-stream, median-block and result signals of median_window_feeder.
// slave  : the feeder's own view (pixels in, median samples out, results out).
// master : the surrounding environment's view (pixel source, median block, result sink).
interface median_window_feeder_if #(
    parameter int W = 8
);
    logic [W-1:0] PIX_IN;
    logic         PIX_VALID;
    logic         PIX_SOF;
    logic         PIX_READY;
    logic [W-1:0] MED_DI;
    logic         MED_DSI;
    logic [W-1:0] MED_DO;
    logic         MED_DSO;
    logic [W-1:0] RES_OUT;
    logic         RES_VALID;

    modport slave (
        input  PIX_IN, PIX_VALID, PIX_SOF, MED_DO, MED_DSO,
        output PIX_READY, MED_DI, MED_DSI, RES_OUT, RES_VALID
    );

    modport master (
        output PIX_IN, PIX_VALID, PIX_SOF, MED_DO, MED_DSO,
        input  PIX_READY, MED_DI, MED_DSI, RES_OUT, RES_VALID
    );
endinterface

// File: rtl/median_window_feeder.sv
// median_window_feeder: builds 3x3 neighbourhoods from a raster pixel stream
// using two line buffers, serialises each complete window into a median block
// as nine contiguous MED_DSI samples, then captures the first MED_DO result.
// Upstream is stalled (PIX_READY=0) while a window is in flight.
//
// Build option MEDIAN_BORDER_EN: when defined, pixels whose window is
// incomplete are echoed straight to RES_OUT one cycle after acceptance, so
// every accepted pixel yields exactly one result. When undefined (default),
// border pixels produce no result.
module median_window_feeder #(
    parameter int W     = 8,
    parameter int IMG_W = 16
) (
    input  logic CLK,
    input  logic nRST,
    median_window_feeder_if.slave bus
);

    localparam int              COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_reg;
    logic [COL_W-1:0] col_reg;
    logic [1:0]       row_reg;
    logic [3:0]       cnt_reg;
    logic             pix_ready_reg;
    logic             med_dsi_reg;
    logic [W-1:0]     med_di_reg;
    logic             res_valid_reg;
    logic [W-1:0]     res_out_reg;

    // Line buffers are read in the same cycle the pixel is accepted, because
    // the new window column is needed on that edge to start the burst one
    // cycle later; they are therefore read combinationally.
    logic [W-1:0] line0_mem [IMG_W];
    logic [W-1:0] line1_mem [IMG_W];

    // Window stored in raster order: 0..2 top row, 3..5 middle, 6..8 bottom.
    logic [W-1:0] win_reg  [9];
    logic [W-1:0] win_next [9];

    logic             accept;
    logic [COL_W-1:0] col_use;
    logic [1:0]       row_use;
    logic [COL_W-1:0] col_next;
    logic [1:0]       row_next;
    logic             win_complete;
    logic [W-1:0]     top_new;
    logic [W-1:0]     mid_new;
    logic [3:0]       cnt_inc;

    assign accept  = bus.PIX_VALID & pix_ready_reg;

    // A start-of-frame pixel is always position (0,0), even mid-row.
    assign col_use = bus.PIX_SOF ? '0 : col_reg;
    assign row_use = bus.PIX_SOF ? 2'd0 : row_reg;

    assign col_next = (col_use == COL_LAST) ? '0 : col_use + COL_W'(1);
    assign row_next = ((col_use == COL_LAST) && (row_use != 2'd2)) ? row_use + 2'd1 : row_use;

    // Row saturates at 2, so row==2 means "two full rows already buffered".
    assign win_complete = (row_use == 2'd2) && (col_use >= COL_W'(2));

    assign top_new = line1_mem[col_use];
    assign mid_new = line0_mem[col_use];
    assign cnt_inc = cnt_reg + 4'd1;

    // Window shifts left one column; the right column is the new vertical slice.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_win
            if ((gi % 3) != 2) begin : g_shift
                assign win_next[gi] = win_reg[gi + 1];
            end else if (gi == 2) begin : g_top
                assign win_next[gi] = top_new;
            end else if (gi == 5) begin : g_mid
                assign win_next[gi] = mid_new;
            end else begin : g_bot
                assign win_next[gi] = bus.PIX_IN;
            end
        end
    endgenerate

    // Line buffers and window advance on every accepted pixel; contents need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            line1_mem[col_use] <= mid_new;
            line0_mem[col_use] <= bus.PIX_IN;
            for (int i = 0; i < 9; i++) begin
                win_reg[i] <= win_next[i];
            end
        end
    end

    // Control FSM with position counters and all registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            col_reg       <= '0;
            row_reg       <= 2'd0;
            cnt_reg       <= 4'd0;
            pix_ready_reg <= 1'b0;
            med_dsi_reg   <= 1'b0;
            med_di_reg    <= '0;
            res_valid_reg <= 1'b0;
            res_out_reg   <= '0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    pix_ready_reg <= 1'b1;
                    if (accept) begin
                        col_reg <= col_next;
                        row_reg <= row_next;
                        if (win_complete) begin
                            state_reg     <= SEND;
                            cnt_reg       <= 4'd0;
                            med_dsi_reg   <= 1'b1;
                            med_di_reg    <= win_next[0];
                            pix_ready_reg <= 1'b0;
                        end
`ifdef MEDIAN_BORDER_EN
                        else begin
                            res_out_reg   <= bus.PIX_IN;
                            res_valid_reg <= 1'b1;
                        end
`endif
                    end
                end
                SEND: begin
                    if (cnt_reg == 4'd8) begin
                        state_reg   <= WAIT;
                        med_dsi_reg <= 1'b0;
                    end else begin
                        cnt_reg    <= cnt_inc;
                        med_di_reg <= win_reg[cnt_inc];
                    end
                end
                WAIT: begin
                    if (bus.MED_DSO) begin
                        res_out_reg   <= bus.MED_DO;
                        res_valid_reg <= 1'b1;
                        state_reg     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.MED_DSO) begin
                        state_reg     <= IDLE;
                        pix_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.PIX_READY = pix_ready_reg;
    assign bus.MED_DSI   = med_dsi_reg;
    assign bus.MED_DI    = med_di_reg;
    assign bus.RES_VALID = res_valid_reg;
    assign bus.RES_OUT   = res_out_reg;

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder (IMG_W=4). A raster model of each frame gives
// the expected median samples and results; a stand-in median block answers
// each 9-sample burst with the true median.
module tb_median_window_feeder;

    localparam int W     = 8;
    localparam int IMG_W = 4;

    logic CLK;
    logic nRST;
    logic resp_dso;
    logic spur_dso;
    logic [W-1:0] resp_do;

    median_window_feeder_if #(.W(W)) bus ();

    assign bus.MED_DSO = resp_dso | spur_dso;
    assign bus.MED_DO  = resp_do;

    median_window_feeder #(.W(W), .IMG_W(IMG_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int dso_delay, dso_len;
    int res_cnt  = 0;
    int acc_cnt  = 0;
    int sent_cnt = 0;
    bit exp_busy = 0;
    bit saw_dso  = 0;
    bit rst_seen = 0;
    logic [W-1:0] exp_di[$];
    logic [W-1:0] exp_res[$];
    logic [W-1:0] got_di[$];
    logic [W-1:0] got_res[$];
    logic [W-1:0] hist[$];

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [W-1:0] median9(input logic [W-1:0] a[9]);
        logic [W-1:0] s[9];
        logic [W-1:0] t;
        for (int i = 0; i < 9; i++) s[i] = a[i];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Reset seen at the last rising edge (PIX_READY only rises on an edge).
    initial forever begin
        @(posedge CLK);
        rst_seen = nRST;
    end

    // Stand-in median block: collect 9 samples, answer with their true median.
    initial begin
        int nsamp;
        logic [W-1:0] samp[9];
        resp_dso = 0;
        resp_do  = 0;
        nsamp    = 0;
        forever begin
            @(posedge CLK); #2;
            if (!nRST) nsamp = 0;
            else if (bus.MED_DSI) begin
                samp[nsamp] = bus.MED_DI;
                nsamp++;
                if (nsamp == 9) begin
                    nsamp = 0;
                    repeat (dso_delay) begin @(posedge CLK); #2; end
                    resp_do  = median9(samp);
                    resp_dso = 1;
                    repeat (dso_len) begin @(posedge CLK); #2; end
                    resp_dso = 0;
                end
            end
        end
    end

    // Compare process: checks every DUT output against the model each cycle.
    initial forever begin
        @(negedge CLK);
        if (!nRST) begin
            exp_di.delete();
            exp_res.delete();
            hist.delete();
            exp_busy = 0;
            saw_dso  = 0;
        end else begin
            chk("pix_ready", bus.PIX_READY, int'(rst_seen && !exp_busy));
            if (bus.PIX_VALID && bus.PIX_READY) acc_cnt++;
            if (bus.MED_DSI) begin
                got_di.push_back(bus.MED_DI);
                if (exp_di.size() == 0) chk("dsi_unexpected", bus.MED_DSI, 0);
                else chk("med_di", bus.MED_DI, exp_di.pop_front());
            end
            if (bus.RES_VALID) begin
                got_res.push_back(bus.RES_OUT);
                res_cnt++;
                if (exp_res.size() == 0) chk("res_unexpected", bus.RES_VALID, 0);
                else chk("res_out", bus.RES_OUT, exp_res.pop_front());
            end
            if (exp_busy) begin
                if (bus.MED_DSO) saw_dso = 1;
                else if (saw_dso) begin exp_busy = 0; saw_dso = 0; end
            end
        end
    end

    task automatic send_pixel(input int p, input bit sof);
        int k, r, c;
        bit ok;
        logic [W-1:0] w[9];
        bus.PIX_IN    = p[W-1:0];
        bus.PIX_SOF   = sof;
        bus.PIX_VALID = 1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (bus.PIX_READY) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", bus.PIX_READY, 1);
            return;
        end
        @(posedge CLK); #1;
        sent_cnt++;
        if (sof) hist.delete();
        hist.push_back(p[W-1:0]);
        k = hist.size() - 1;
        r = k / IMG_W;
        c = k % IMG_W;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[i*3+j] = hist[k - (2-i)*IMG_W - (2-j)];
            for (int i = 0; i < 9; i++) exp_di.push_back(w[i]);
            exp_res.push_back(median9(w));
            exp_busy = 1;
            saw_dso  = 0;
        end else begin
`ifdef MEDIAN_BORDER_EN
            exp_res.push_back(p[W-1:0]);
`endif
        end
    endtask

    task automatic end_stream();
        bus.PIX_VALID = 0;
        bus.PIX_SOF   = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (exp_res.size() == 0 && exp_di.size() == 0 && !exp_busy && bus.PIX_READY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", exp_res.size(), 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int r0, v, first_med_idx;
        int lit_di[9];
        int lit_a[$];
        int exp_frame_cnt, exp_cont_cnt;
        lit_di = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`ifdef MEDIAN_BORDER_EN
        lit_a = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 5, 6, 12, 13, 9, 10};
        exp_frame_cnt = 16;
        exp_cont_cnt  = 3;
        first_med_idx = 10;
`else
        lit_a = '{5, 6, 9, 10};
        exp_frame_cnt = 4;
        exp_cont_cnt  = 1;
        first_med_idx = 0;
`endif
        nRST = 0;
        bus.PIX_VALID = 0;
        bus.PIX_SOF   = 0;
        bus.PIX_IN    = 0;
        spur_dso  = 0;
        dso_delay = 1;
        dso_len   = 5;

        // Reset state
        repeat (3) @(posedge CLK); #1;
        chk("rst_med_dsi", bus.MED_DSI, 0);
        chk("rst_med_di", bus.MED_DI, 0);
        chk("rst_res_valid", bus.RES_VALID, 0);
        chk("rst_res_out", bus.RES_OUT, 0);
        chk("rst_pix_ready", bus.PIX_READY, 0);
        nRST = 1;
        repeat (2) @(posedge CLK); #1;
        chk("ready_after_reset", bus.PIX_READY, 1);

        // Frame 0..15, PIX_VALID held high, DSO held 5 cycles
        got_di.delete(); got_res.delete(); r0 = res_cnt;
        for (int i = 0; i < 16; i++) send_pixel(i, i == 0);
        end_stream();
        wait_idle();
        $display("[TB] ramp frame: %0d results", res_cnt - r0);
        chk("ramp_result_count", res_cnt - r0, exp_frame_cnt);
        for (int i = 0; i < 9; i++) begin
            v = (i < got_di.size()) ? int'(got_di[i]) : -1;
            chk("burst0_di", v, lit_di[i]);
        end
        for (int i = 0; i < lit_a.size(); i++) begin
            v = (i < got_res.size()) ? int'(got_res[i]) : -1;
            chk("ramp_result", v, lit_a[i]);
        end

        // Row continues without SOF: one more window at (4,2) with median 13
        got_res.delete(); r0 = res_cnt;
        send_pixel(20, 0); send_pixel(21, 0); send_pixel(22, 0);
        end_stream();
        wait_idle();
        $display("[TB] continuation: %0d results", res_cnt - r0);
        chk("cont_count", res_cnt - r0, exp_cont_cnt);
        v = (got_res.size() > 0) ? int'(got_res[got_res.size()-1]) : -1;
        chk("cont_median", v, 13);

        // DSO while idle is ignored
        r0 = res_cnt;
        spur_dso = 1;
        repeat (3) @(posedge CLK); #1;
        spur_dso = 0;
        repeat (2) @(posedge CLK); #1;
        $display("[TB] spurious DSO: %0d results", res_cnt - r0);
        chk("spurious_dso", res_cnt - r0, 0);

        // Constant frame (SOF mid-row), short DSO
        dso_delay = 3; dso_len = 1;
        got_res.delete(); r0 = res_cnt;
        for (int i = 0; i < 16; i++) send_pixel(7, i == 0);
        end_stream();
        wait_idle();
        $display("[TB] constant frame: %0d results", res_cnt - r0);
        chk("const_count", res_cnt - r0, exp_frame_cnt);
        for (int i = 0; i < got_res.size(); i++) chk("const_value", got_res[i], 7);

        // Reset during SEND at cnt=4
        dso_delay = 1; dso_len = 5;
        for (int i = 0; i < 11; i++) send_pixel(i, i == 0);
        end_stream();
        repeat (4) @(posedge CLK); #1;
        chk("mid_burst_dsi", bus.MED_DSI, 1);
        chk("mid_burst_di", bus.MED_DI, 5);
        r0 = res_cnt;
        nRST = 0;
        #1;
        chk("abort_dsi", bus.MED_DSI, 0);
        chk("abort_ready", bus.PIX_READY, 0);
        repeat (2) @(posedge CLK); #1;
        nRST = 1;
        repeat (4) @(posedge CLK); #1;
        $display("[TB] reset abort: %0d results", res_cnt - r0);
        chk("abort_no_result", res_cnt - r0, 0);

        got_res.delete(); r0 = res_cnt;
        for (int i = 0; i < 16; i++) send_pixel(i, i == 0);
        end_stream();
        wait_idle();
        v = (first_med_idx < got_res.size()) ? int'(got_res[first_med_idx]) : -1;
        $display("[TB] post-reset frame: %0d results, first median %0d", res_cnt - r0, v);
        chk("post_reset_first", v, 5);
        chk("post_reset_count", res_cnt - r0, exp_frame_cnt);

        chk("accept_count", acc_cnt, sent_cnt);
        chk("leftover_results", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
Upstream companion of the median filter controller. Takes a raster pixel stream and builds 3x3 neighbourhoods with two line buffers. Serialises each complete window into the median block as nine contiguous DSI-qualified samples, then waits for DSO and captures DO. Emits one filtered result per complete window, with upstream back-pressure while a window is in flight.

Parameters:
W, 8, pixel width in bits
IMG_W, 16, image width in pixels (>=3)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
PIX_IN  in  W  input pixel
PIX_VALID  in  1  PIX_IN valid
PIX_SOF  in  1  qualifies PIX_IN as first pixel of frame
PIX_READY  out  1  feeder can accept a pixel this cycle
MED_DI  out  W  sample to median block
MED_DSI  out  1  sample valid to median block
MED_DO  in  W  median result from median block
MED_DSO  in  1  result valid from median block
RES_OUT  out  W  filtered pixel
RES_VALID  out  1  one-cycle pulse, RES_OUT valid

Behaviour:
- Reset (async, nRST=0): state IDLE; col=0, row=0; PIX_READY=0 during reset, 1 in first IDLE cycle after; MED_DI=0, MED_DSI=0, RES_OUT=0, RES_VALID=0. Line buffer contents don't care.
- Accept: a pixel is taken when PIX_VALID & PIX_READY. PIX_READY=1 only in IDLE.
- Counters: col runs 0..IMG_W-1 and wraps to 0; row increments on wrap and saturates at 2.
  - If PIX_SOF is set on an accepted pixel, that pixel is position (0,0): col and row are forced to 0 before use. SOF is allowed mid-row; no flush.
- Line buffers: two IMG_W-deep arrays, written at col on each accept (line1<=line0[col], line0<=PIX_IN).
- Window shift: the 3x3 window shifts left one column per accept. New right column = {line1[col], line0[col], PIX_IN}, top to bottom.
- Window complete: accepted pixel has row==2 and col>=2.
- FSM:
  - IDLE: on accept of a complete window -> SEND, cnt=0. Otherwise stay.
  - SEND: MED_DSI=1 for exactly 9 consecutive cycles. MED_DI = window in raster order: top-left, top-mid, top-right, mid row, bottom row. cnt 0..8. After cnt==8 -> WAIT, MED_DSI=0.
  - WAIT: on the first cycle MED_DSO==1, register RES_OUT<=MED_DO, pulse RES_VALID for 1 cycle -> DRAIN.
  - DRAIN: stay while MED_DSO==1 (the median block holds DSO for several cycles; only one capture per window); on MED_DSO==0 -> IDLE.
- Latency: accept-to-first-DSI 1 cycle. RES_VALID 1 cycle after DSO rises.
- MED_DI is registered and holds its last value when MED_DSI=0.
- PIX_VALID/PIX_SOF are ignored outside IDLE. Upstream must hold its data until PIX_READY.
- MED_DSO asserted in IDLE or SEND: ignored, no capture.
- Reset mid-SEND/WAIT: abort immediately, DSI drops asynchronously, no RES_VALID; counters restart at (0,0).
- No arithmetic beyond counters; counter widths are $clog2(IMG_W) and 2 bits (row), 4 bits (cnt).

Optional Feature:
MEDIAN_BORDER_EN
- Defined: an accepted pixel whose window is incomplete (row<2 or col<2) is a border pixel. It is passed through with no median transaction: RES_OUT<=PIX_IN, RES_VALID=1 the next cycle, FSM stays IDLE, PIX_READY stays 1. Result count equals accepted pixel count.
- Undefined: border pixels produce no output; result count per frame = (IMG_H-2)*(IMG_W-2) for rows fully sent.

Test Plan:
- IMG_W=4, frame 0..15 raster with SOF on 0, median model returns true median: first DSI burst after pixel 10 carries 0,1,2,4,5,6,8,9,10. Result sequence 5,6,9,10.
- Constant frame all 7 -> every RES_OUT=7. Exactly 4 RES_VALID pulses per 16-pixel frame (macro off).
- Bench holds MED_DSO high 5 cycles -> exactly one RES_VALID. PIX_READY=0 from accept of pixel 10 until the cycle after DSO falls.
- PIX_VALID held high throughout -> no pixel lost or duplicated. Input count equals accept count, checked against PIX_READY.
- nRST pulsed at SEND cnt=4 -> MED_DSI=0 immediately, no RES_VALID. Next SOF frame produces a correct first result of 5.
- MEDIAN_BORDER_EN defined, same 0..15 frame -> 16 RES_VALID pulses. Pixels 0..9 echoed 1 cycle after accept, and median results 5,6,9,10 appear at indices 10,11,14,15 (the border pixels 12,13 pass through in between).
